// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution: raster-order pixels in, one result per interior window out.
// Two row buffers feed a 3x3 window; a three-stage MAC (multiply, sum, bias/clamp) follows acceptance.
module conv3x3_stream #(
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = DATA_W + COEF_W + 4,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [9*COEF_W-1:0]      mask,
    input  logic signed [COEF_W-1:0] bias,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last
);

    localparam int CW   = $clog2(IMG_W);
    localparam int ROWW = $clog2(IMG_H);
    localparam int PW   = DATA_W + 1 + COEF_W;
    localparam int RW   = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;

    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_H - 1);
    localparam logic [CW-1:0]   COL_TWO  = CW'(2);
    localparam logic [ROWW-1:0] ROW_TWO  = ROWW'(2);

    function automatic logic signed [COEF_W-1:0] coef_at(input logic [9*COEF_W-1:0] m,
                                                         input int k);
        return $signed(m[k*COEF_W +: COEF_W]);
    endfunction

    // Negative results clamp to zero with or without ReLU because the output is unsigned.
    function automatic logic [OUT_W-1:0] clamp_out(input logic signed [RW-1:0] r,
                                                   input logic relu);
        logic signed [RW-1:0] max_v;
        max_v = {{(RW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
        if (r[RW-1] && relu) begin
            return '0;
        end else if (r[RW-1]) begin
            return '0;
        end else if (r > max_v) begin
            return '1;
        end else begin
            return r[OUT_W-1:0];
        end
    endfunction

    logic                     advance;
    logic                     accept;
    logic                     first_px;
    logic                     emit;
    logic                     frame_end;

    logic [CW-1:0]            col_q, col_d;
    logic [ROWW-1:0]          row_q, row_d;

    logic [9*COEF_W-1:0]      mask_q;
    logic signed [COEF_W-1:0] bias_q;
    logic                     relu_q;

    logic [DATA_W-1:0]        lb0_q [IMG_W];
    logic [DATA_W-1:0]        lb1_q [IMG_W];
    logic [DATA_W-1:0]        win_q [9];

    logic                     vld_p0_q, last_p0_q;
    logic                     vld_p1_q, last_p1_q;
    logic                     vld_p2_q, last_p2_q;

    logic signed [PW-1:0]     prod_d [9];
    logic signed [PW-1:0]     prod_p1_q [9];
    logic signed [COEF_W-1:0] bias_p1_q;
    logic                     relu_p1_q;

    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_p2_q;
    logic signed [COEF_W-1:0] bias_p2_q;
    logic                     relu_p2_q;

    logic [OUT_W-1:0]         res_d;
    logic                     out_valid_q;
    logic [OUT_W-1:0]         out_data_q;
    logic                     out_last_q;

    assign advance   = !out_valid_q || out_ready;
    assign accept    = in_valid && advance;
    assign in_ready  = advance;
    assign first_px  = (row_q == '0) && (col_q == '0);
    assign emit      = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = PW'($signed({1'b0, win_q[k]})) * PW'(coef_at(mask_q, k));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) begin
            sum_d = sum_d + ACC_W'(prod_p1_q[k]);
        end
    end

    assign res_d = clamp_out(RW'(sum_p2_q) - RW'(bias_p2_q), relu_p2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            vld_p0_q    <= 1'b0;
            last_p0_q   <= 1'b0;
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            vld_p2_q    <= 1'b0;
            last_p2_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (advance) begin
                // p0: window holds the pixel just accepted
                vld_p0_q    <= accept && emit;
                last_p0_q   <= accept && frame_end;
                // p1: products; p2: sum; output: bias, clamp
                vld_p1_q    <= vld_p0_q;
                last_p1_q   <= last_p0_q;
                vld_p2_q    <= vld_p1_q;
                last_p2_q   <= last_p1_q;
                out_valid_q <= vld_p2_q;
                out_last_q  <= last_p2_q;
                out_data_q  <= res_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_data;
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]   <= win_q[3*r+1];
                win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[2] <= lb1_q[col_q];
            win_q[5] <= lb0_q[col_q];
            win_q[8] <= in_data;
            if (first_px) begin
                mask_q <= mask;
                bias_q <= bias;
                relu_q <= relu_en;
            end
        end
        // Bias and ReLU travel with the data so a new frame's config cannot reach old windows.
        if (advance) begin
            prod_p1_q <= prod_d;
            bias_p1_q <= bias_q;
            relu_p1_q <= relu_q;
            sum_p2_q  <= sum_d;
            bias_p2_q <= bias_p1_q;
            relu_p2_q <= relu_p1_q;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 5x4 image: kernel table, latency, framing,
// back-pressure, mid-frame reset and config latch, plus an 8-bit-output saturation instance.
module tb_conv3x3_stream;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct packed {
        logic [8:0][15:0] m;
        logic [15:0]      b;
        logic             relu;
        logic             ramp;
        logic [15:0]      pix;
        logic [5:0][31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               in_valid, in_ready;
    logic [15:0]        in_data;
    logic [8:0][15:0]   mask;
    logic signed [15:0] bias;
    logic               relu_en;
    logic               out_valid, out_ready, out_last;
    logic [31:0]        out_data;

    logic               in8_valid, in8_ready;
    logic [15:0]        in8_data;
    logic [8:0][15:0]   mask8;
    logic signed [15:0] bias8;
    logic               relu8;
    logic               out8_valid, out8_ready, out8_last;
    logic [7:0]         out8_data;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(16), .COEF_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mask(mask), .bias(bias), .relu_en(relu_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(16), .COEF_W(16), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
        .mask(mask8), .bias(bias8), .relu_en(relu8), .out_valid(out8_valid),
        .out_ready(out8_ready), .out_data(out8_data), .out_last(out8_last));

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          first_vld = -1;
    int          lat_acc = 0;
    int          n8 = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] got_d [$];
    bit          got_l [$];
    int          got_c [$];
    vec_t        vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [8:0][15:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [8:0][15:0] m;
        m[0] = 16'(a0); m[1] = 16'(a1); m[2] = 16'(a2);
        m[3] = 16'(a3); m[4] = 16'(a4); m[5] = 16'(a5);
        m[6] = 16'(a6); m[7] = 16'(a7); m[8] = 16'(a8);
        return m;
    endfunction

    function automatic vec_t mkvec(input logic [8:0][15:0] m, input int b, input bit relu,
                                   input bit ramp, input int pix,
                                   input int e0, e1, e2, e3, e4, e5);
        vec_t v;
        v.m = m; v.b = 16'(b); v.relu = relu; v.ramp = ramp; v.pix = 16'(pix);
        v.exp[0] = 32'(e0); v.exp[1] = 32'(e1); v.exp[2] = 32'(e2);
        v.exp[3] = 32'(e3); v.exp[4] = 32'(e4); v.exp[5] = 32'(e5);
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin : mon
        bit          stall_prev;
        logic [31:0] pd;
        bit          pl;
        stall_prev = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, pd);
                    chk("hold_last", out_last, pl);
                end
                if (out_valid && first_vld < 0) first_vld = cyc;
                if (out_valid && out_ready) begin
                    got_d.push_back(out_data);
                    got_l.push_back(out_last);
                    got_c.push_back(cyc);
                end
                stall_prev = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
                if (out8_valid && out8_ready) begin
                    chk("sat8_data", out8_data, 255);
                    n8++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        first_vld = -1;
    endtask

    task automatic push(input logic [15:0] d, input bit gaps);
        int t;
        int g;
        bit acc;
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            step();
            t++;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL push_timeout: pixel %0d not accepted in %0d cycles", d, t);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit ramp, input logic [15:0] cval, input bit gaps,
                              input int npix, input bit chg_cfg);
        int r;
        int c;
        for (int i = 0; i < npix; i++) begin
            r = (i / W) % H;
            c = i % W;
            push(ramp ? 16'(10 * r + c) : cval, gaps);
            if (r == 2 && c == 2) lat_acc = cyc;
            if (chg_cfg && i == 0) begin
                mask = mk9(1, 1, 1, 1, 1, 1, 1, 1, 1);
                bias = 16'sd100;
            end
        end
    endtask

    task automatic wait_outs(input int n, input string name);
        int t;
        t = 0;
        while (got_d.size() < n && t < 3000) begin
            step();
            t++;
        end
        repeat (8) step();
        chk({name, "_count"}, got_d.size(), n);
    endtask

    task automatic check_seq(input string name, input logic [5:0][31:0] exp);
        for (int i = 0; i < 6; i++) begin
            if (i < got_d.size()) begin
                chk($sformatf("%s_data%0d", name, i), got_d[i], exp[i]);
                chk($sformatf("%s_last%0d", name, i), got_l[i], (i == 5));
            end
        end
    endtask

    initial begin
        vecs[0] = mkvec(mk9(0, 0, 0, 0, 1, 0, 0, 0, 0), 0, 1'b0, 1'b1, 0,
                        11, 12, 13, 21, 22, 23);
        vecs[1] = mkvec(mk9(1, 1, 1, 1, 1, 1, 1, 1, 1), 9, 1'b0, 1'b0, 5,
                        36, 36, 36, 36, 36, 36);
        vecs[2] = mkvec(mk9(0, 0, 0, 0, -1, 0, 0, 0, 0), 0, 1'b1, 1'b0, 7,
                        0, 0, 0, 0, 0, 0);
        vecs[3] = mkvec(mk9(0, 0, 0, 0, -1, 0, 0, 0, 0), 0, 1'b0, 1'b0, 7,
                        0, 0, 0, 0, 0, 0);
        vecs[4] = mkvec(mk9(0, 0, 0, 0, 1, 0, 0, 0, 0), -3, 1'b0, 1'b0, 7,
                        10, 10, 10, 10, 10, 10);
        vecs[5] = mkvec(mk9(1, 2, 3, 4, 5, 6, 7, 8, 9), 0, 1'b1, 1'b1, 0,
                        681, 726, 771, 1131, 1176, 1221);

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; mask = '0; bias = '0; relu_en = 1'b0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_data = '0; bias8 = '0; relu8 = 1'b0; out8_ready = 1'b1;
        mask8 = mk9(100, 100, 100, 100, 100, 100, 100, 100, 100);
        repeat (3) step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        in8_valid = 1'b1;
        in8_data  = 16'd255;
        repeat (W * H) step();
        in8_valid = 1'b0;
        repeat (8) step();
        chk("sat8_count", n8, 6);

        for (int v = 0; v < 6; v++) begin
            mask = vecs[v].m;
            bias = vecs[v].b;
            relu_en = vecs[v].relu;
            clear();
            step();
            send_frame(vecs[v].ramp, vecs[v].pix, 1'b0, W * H, 1'b0);
            wait_outs(6, $sformatf("v%0d", v));
            check_seq($sformatf("v%0d", v), vecs[v].exp);
            chk($sformatf("v%0d_latency", v), first_vld - lat_acc, 3);
        end

        mask = mk9(1, 1, 1, 1, 1, 1, 1, 1, 1);
        bias = 16'sd9;
        relu_en = 1'b0;
        clear();
        send_frame(1'b0, 16'd5, 1'b0, 2 * W * H, 1'b0);
        wait_outs(12, "b2b");
        if (got_d.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("b2b_data%0d", i), got_d[i], 36);
                chk($sformatf("b2b_last%0d", i), got_l[i], (i % 6 == 5));
            end
            chk("b2b_gap_in_row", got_c[1] - got_c[0], 1);
            chk("b2b_gap_row", got_c[3] - got_c[2], 3);
            chk("b2b_gap_frame", got_c[6] - got_c[5], 13);
        end

        mask = vecs[0].m;
        bias = '0;
        clear();
        rand_ready = 1'b1;
        send_frame(1'b1, '0, 1'b1, W * H, 1'b0);
        wait_outs(6, "rand");
        rand_ready = 1'b0;
        out_ready = 1'b1;
        check_seq("rand", vecs[0].exp);
        step();

        clear();
        out_ready = 1'b0;
        send_frame(1'b1, '0, 1'b0, 13, 1'b0);
        repeat (4) step();
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 11);
        chk("stall_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        clear();
        send_frame(1'b1, '0, 1'b0, 9, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        clear();
        send_frame(1'b1, '0, 1'b0, W * H, 1'b1);
        wait_outs(6, "after_rst");
        check_seq("after_rst", vecs[0].exp);
        chk("after_rst_latency", first_vld - lat_acc, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
